div: RTL and testbench
======================

# div

- Multi-cycle 32-bit integer divider for the EX stage.
- Performs DIV/DIVU by radix-2 restoring division, one quotient bit per cycle.
- Returns remainder in HI and quotient in LO.
- Acts as the requesting end of the pipeline stall interface: drives the EX stall request into the stall controller for as long as a division is in flight.

## Interface
Parameters
- DATA_W, 32, operand width; results are 2*DATA_W wide.

Ports
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- start_i  in  1  EX requests a division. Held high until ready_o is seen.
- signed_div_i  in  1  1 = signed DIV, 0 = DIVU. Sampled with start_i in FREE.
- opdata1_i  in  DATA_W  dividend. Sampled with start_i in FREE.
- opdata2_i  in  DATA_W  divisor. Sampled with start_i in FREE.
- annul_i  in  1  flush; aborts an in-flight division.
- result_o  out  2*DATA_W  {remainder, quotient}; valid while ready_o = 1.
- ready_o  out  1  result valid.
- stallreq_o  out  1  stall request to the stall controller, which maps it to stall = 6'b001111.

## Operation
- States: FREE, ZERO, ON, END.
- Reset: state = FREE, cnt = 0, ready_o = 0, result_o = 0.
- FREE:
  - On start_i & ~annul_i, latch operands.
  - Divisor == 0 → ZERO.
  - Divisor != 0 → ON, cnt = 0, partial remainder = 0, working dividend = |opdata1_i|.
  - In signed mode both operands are converted to magnitude; signs are latched.
- ZERO: quotient = 0, remainder = 0 → END.
- ON:
  - Per cycle: shift {rem, dvd} left by 1; trial = rem − |divisor|.
  - Trial non-negative: rem = trial, quotient bit = 1. Otherwise quotient bit = 0.
  - cnt increments; the step with cnt == 31 → END.
  - annul_i → FREE, ready_o = 0, nothing registered.
- END:
  - On entry edge, register result_o and set ready_o = 1.
  - Signed mode: quotient negated if operand signs differ; remainder takes the dividend's sign.
  - Remain while start_i = 1. When start_i = 0 → FREE, ready_o = 0, result_o = 0.
- Arithmetic:
  - Trial subtraction is DATA_W+1 bits wide; carry-out selects the quotient bit.
  - Signed 0x80000000 / −1 wraps: quotient 0x80000000, remainder 0. No exception.
- stallreq_o = start_i & ~ready_o & ~annul_i, combinational.
- annul_i in FREE blocks the start. annul_i in ZERO or END forces FREE.

## Timing
- start_i sampled at edge E (state FREE).
- Nonzero divisor: iterations occur on edges E+1…E+32. END entered at E+32; result_o and ready_o valid after edge E+33. stallreq_o is high from E through E+33.
- Zero divisor: ZERO after E, END after E+1, ready_o after E+2.
- Back-to-back: a new start is accepted only in FREE. Start must drop for at least one edge between divisions.
- Reset mid-division: immediate FREE with all outputs 0, independent of clk.

## Configuration
- DIV_SIGNED_EN:
  - Defined: signed_div_i honoured, with magnitude conversion and sign fixup as above.
  - Undefined: signed_div_i ignored; every division is unsigned, and the sign logic is removed.

## Structure
- Shared defines file (include with the other pipeline defines):
  - State encodings DivFree, DivByZero, DivOn, DivEnd (2 bits).
  - DivResultReady / DivResultNotReady.
  - DivStart / DivStop.
  - Existing Stop/NoStop reused for stallreq_o.
- One sub-module: div_step, a combinational single restoring step.
  - Inputs: rem, dvd, divisor.
  - Outputs: next rem, next dvd, quotient bit.
  - Instantiated once in ON.

## Test plan
- Unsigned 100 / 7, start held → after E+33, result_o = {32'd2, 32'd14}, ready_o = 1; stallreq_o high for exactly 34 edges, then low.
- Signed −100 / 7 (DIV_SIGNED_EN) → quotient 0xFFFFFFF2 (−14), remainder 0xFFFFFFFE (−2).
- Divisor 0, dividend 0x12345678 → ready_o after E+2, result_o = 0.
- Signed 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0.
- annul_i pulsed at E+10 → state FREE next edge, ready_o stays 0, stallreq_o low. A subsequent start of 9 / 3 → {0, 3}.
- rst asserted at E+20, asynchronously → outputs 0 immediately. After release, start 0xFFFFFFFF / 1 unsigned → {0, 0xFFFFFFFF}.

Source files
------------

// File: rtl/div_pkg.sv
// div_pkg: shared encodings for the EX-stage divider and its stall handshake.
//   div_state_e       : divider FSM states (DivFree, DivByZero, DivOn, DivEnd)
//   DivResultReady/NotReady : ready_o levels
//   DivStart/DivStop  : start_i levels
//   Stop/NoStop       : stall request levels seen by the stall controller
package div_pkg;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;
  localparam logic Stop              = 1'b1;
  localparam logic NoStop            = 1'b0;

endpackage

// File: rtl/div_step.sv
// div_step: one combinational radix-2 restoring division step.
//   rem_i     : partial remainder (always < divisor_i)
//   dvd_i     : working dividend; its MSB is shifted into the remainder
//   divisor_i : divisor magnitude
//   rem_o     : next partial remainder
//   dvd_o     : dividend shifted left by one, LSB left as 0
//   qbit_o    : quotient bit produced by this step
module div_step #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] rem_i,
  input  logic [DATA_W-1:0] dvd_i,
  input  logic [DATA_W-1:0] divisor_i,
  output logic [DATA_W-1:0] rem_o,
  output logic [DATA_W-1:0] dvd_o,
  output logic              qbit_o
);

  logic [DATA_W:0]   shifted;
  logic [DATA_W+1:0] trial;
  logic              unused_trial_msb;

  // Shifted remainder can reach 2*divisor-1, hence DATA_W+1 bits; the extra
  // top bit of the subtraction is the borrow that decides the quotient bit.
  assign shifted = {rem_i, dvd_i[DATA_W-1]};
  assign trial   = {1'b0, shifted} - {2'b00, divisor_i};
  assign qbit_o  = ~trial[DATA_W+1];
  // A non-negative trial is below the divisor, so its bit DATA_W is always 0.
  assign unused_trial_msb = trial[DATA_W];
  assign rem_o   = qbit_o ? trial[DATA_W-1:0] : shifted[DATA_W-1:0];
  assign dvd_o   = {dvd_i[DATA_W-2:0], 1'b0};

endmodule

// File: rtl/div.sv
// div: multi-cycle restoring divider for the EX stage (DIV/DIVU).
//   clk, rst (async, active-low)
//   start_i, signed_div_i, opdata1_i (dividend), opdata2_i (divisor), annul_i
//   result_o = {remainder, quotient}, valid while ready_o
//   stallreq_o : EX stall request while a division is outstanding
// Build option: DIV_SIGNED_EN enables signed DIV (magnitude conversion and
// sign fixup); without it signed_div_i is ignored and all divisions are DIVU.
module div
  import div_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic                signed_div_i,
  input  logic [DATA_W-1:0]   opdata1_i,
  input  logic [DATA_W-1:0]   opdata2_i,
  input  logic                annul_i,
  output logic [2*DATA_W-1:0] result_o,
  output logic                ready_o,
  output logic                stallreq_o
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

  div_state_e          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   rem_q, rem_d;
  logic [DATA_W-1:0]   dvd_q, dvd_d;
  logic [DATA_W-1:0]   dsr_q, dsr_d;
  logic [2*DATA_W-1:0] result_q, result_d;
  logic                ready_q, ready_d;

  logic [DATA_W-1:0]   op1_mag, op2_mag, quo_fix, rem_fix;
  logic [DATA_W-1:0]   step_rem, step_dvd;
  logic                step_qbit;

`ifdef DIV_SIGNED_EN
  logic quo_neg_q, quo_neg_d;
  logic rem_neg_q, rem_neg_d;
  logic op1_neg, op2_neg;

  assign op1_neg = signed_div_i & opdata1_i[DATA_W-1];
  assign op2_neg = signed_div_i & opdata2_i[DATA_W-1];
  assign op1_mag = op1_neg ? (~opdata1_i + 1'b1) : opdata1_i;
  assign op2_mag = op2_neg ? (~opdata2_i + 1'b1) : opdata2_i;
  // Quotient truncates toward zero; remainder follows the dividend's sign.
  // 0x80000000 / -1 wraps back to 0x80000000 through the negation.
  assign quo_fix = quo_neg_q ? (~dvd_q + 1'b1) : dvd_q;
  assign rem_fix = rem_neg_q ? (~rem_q + 1'b1) : rem_q;
`else
  logic unused_signed_div;

  assign unused_signed_div = signed_div_i;
  assign op1_mag = opdata1_i;
  assign op2_mag = opdata2_i;
  assign quo_fix = dvd_q;
  assign rem_fix = rem_q;
`endif

  div_step #(.DATA_W(DATA_W)) u_step (
    .rem_i     (rem_q),
    .dvd_i     (dvd_q),
    .divisor_i (dsr_q),
    .rem_o     (step_rem),
    .dvd_o     (step_dvd),
    .qbit_o    (step_qbit)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    dvd_d    = dvd_q;
    dsr_d    = dsr_q;
    result_d = result_q;
    ready_d  = ready_q;
`ifdef DIV_SIGNED_EN
    quo_neg_d = quo_neg_q;
    rem_neg_d = rem_neg_q;
`endif
    case (state_q)
      DivFree: begin
        ready_d  = DivResultNotReady;
        result_d = '0;
        if (start_i == DivStart && !annul_i) begin
          dsr_d = op2_mag;
`ifdef DIV_SIGNED_EN
          quo_neg_d = op1_neg ^ op2_neg;
          rem_neg_d = op1_neg;
`endif
          if (opdata2_i == '0) begin
            state_d = DivByZero;
          end else begin
            state_d = DivOn;
            cnt_d   = '0;
            rem_d   = '0;
            dvd_d   = op1_mag;
          end
        end
      end
      DivByZero: begin
        if (annul_i) begin
          state_d = DivFree;
        end else begin
          // Division by zero yields zero quotient and zero remainder.
          rem_d   = '0;
          dvd_d   = '0;
          state_d = DivEnd;
        end
      end
      DivOn: begin
        if (annul_i) begin
          state_d = DivFree;
          ready_d = DivResultNotReady;
        end else begin
          rem_d = step_rem;
          // The working dividend register fills with quotient bits from the LSB.
          dvd_d = step_dvd | {{(DATA_W-1){1'b0}}, step_qbit};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_CNT) begin
            state_d = DivEnd;
          end
        end
      end
      DivEnd: begin
        if (annul_i || (ready_q && start_i == DivStop)) begin
          state_d  = DivFree;
          ready_d  = DivResultNotReady;
          result_d = '0;
        end else begin
          result_d = {rem_fix, quo_fix};
          ready_d  = DivResultReady;
        end
      end
      default: state_d = DivFree;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= DivFree;
      cnt_q    <= '0;
      rem_q    <= '0;
      dvd_q    <= '0;
      dsr_q    <= '0;
      result_q <= '0;
      ready_q  <= DivResultNotReady;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      dvd_q    <= dvd_d;
      dsr_q    <= dsr_d;
      result_q <= result_d;
      ready_q  <= ready_d;
    end
  end

`ifdef DIV_SIGNED_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
    end else begin
      quo_neg_q <= quo_neg_d;
      rem_neg_q <= rem_neg_d;
    end
  end
`endif

  assign result_o   = result_q;
  assign ready_o    = ready_q;
  assign stallreq_o = (start_i & ~ready_q & ~annul_i) ? Stop : NoStop;

endmodule

// File: tb/tb_div.sv
module tb_div;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;
  logic        stallreq_o;

  int vectors = 0;
  int miscompares = 0;

  div #(.DATA_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o),
    .stallreq_o   (stallreq_o)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (time %0t)", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer division. Signed uses 64-bit arithmetic so that
  // 0x80000000 / -1 = 2^31 simply truncates to 0x80000000.
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic sgn);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
`ifdef DIV_SIGNED_EN
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = sa / sb;
      r  = sa % sb;
      return {r[31:0], q[31:0]};
    end
`endif
    sa = longint'(a);
    sb = longint'(b);
    q  = sa / sb;
    r  = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // One complete handshake: start held until ready, then dropped.
  task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic sgn, input logic [63:0] exp);
    int edges, stalls, exp_edges;
    exp_edges = (b == 32'd0) ? 3 : 34;
    edges = 0;
    stalls = 0;
    @(negedge clk);
    opdata1_i = a;
    opdata2_i = b;
    signed_div_i = sgn;
    start_i = 1'b1;
    #1;
    while (edges < 60) begin
      if (stallreq_o) stalls++;
      @(posedge clk);
      #1;
      edges++;
      if (ready_o) break;
      @(negedge clk);
    end
    $display("div %s: %h / %h sgn=%0d -> %h after %0d edges (exp %h)",
             tag, a, b, sgn, result_o, edges, exp);
    chk({tag, ".latency"}, 64'(edges), 64'(exp_edges));
    chk({tag, ".stall_edges"}, 64'(stalls), 64'(exp_edges));
    chk({tag, ".ready"}, 64'(ready_o), 64'd1);
    chk({tag, ".result"}, result_o, exp);
    @(negedge clk);
    chk({tag, ".stall_after_ready"}, 64'(stallreq_o), 64'd0);
    chk({tag, ".result_held"}, result_o, exp);
    start_i = 1'b0;
    @(posedge clk);
    #1;
    chk({tag, ".ready_clear"}, 64'(ready_o), 64'd0);
    chk({tag, ".result_clear"}, result_o, 64'd0);
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic        rs, ms;
    rst = 1'b0;
    start_i = 1'b0;
    signed_div_i = 1'b0;
    opdata1_i = '0;
    opdata2_i = '0;
    annul_i = 1'b0;
    #12;
    chk("reset.ready", 64'(ready_o), 64'd0);
    chk("reset.result", result_o, 64'd0);
    chk("reset.stall", 64'(stallreq_o), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    run_div("u100_7", 32'd100, 32'd7, 1'b0, {32'd2, 32'd14});
    run_div("zero", 32'h12345678, 32'd0, 1'b0, 64'd0);
`ifdef DIV_SIGNED_EN
    run_div("s-100_7", 32'hFFFFFF9C, 32'd7, 1'b1, {32'hFFFFFFFE, 32'hFFFFFFF2});
    run_div("s_wrap", 32'h80000000, 32'hFFFFFFFF, 1'b1, {32'd0, 32'h80000000});
`else
    // signed_div_i must be ignored: unsigned 0x80000000 / 0xFFFFFFFF
    run_div("u_nosign", 32'h80000000, 32'hFFFFFFFF, 1'b1, {32'h80000000, 32'd0});
`endif

    // Annul mid-division
    @(negedge clk);
    opdata1_i = 32'd100;
    opdata2_i = 32'd7;
    signed_div_i = 1'b0;
    start_i = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    annul_i = 1'b1;
    #1;
    chk("annul.stall", 64'(stallreq_o), 64'd0);
    @(posedge clk);
    #1;
    annul_i = 1'b0;
    start_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("annul.ready_low", 64'(ready_o), 64'd0);
      chk("annul.stall_low", 64'(stallreq_o), 64'd0);
    end
    $display("annul: division aborted, ready=%0d", ready_o);
    run_div("after_annul", 32'd9, 32'd3, 1'b0, {32'd0, 32'd3});

    // Async reset mid-division
    @(negedge clk);
    opdata1_i = 32'd1000;
    opdata2_i = 32'd3;
    start_i = 1'b1;
    repeat (20) @(posedge clk);
    #3;
    rst = 1'b0;
    start_i = 1'b0;
    #1;
    chk("rst_mid.ready", 64'(ready_o), 64'd0);
    chk("rst_mid.result", result_o, 64'd0);
    chk("rst_mid.stall", 64'(stallreq_o), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    // Async reset while a result is being presented
    @(negedge clk);
    opdata1_i = 32'd77;
    opdata2_i = 32'd5;
    start_i = 1'b1;
    for (int i = 0; i < 60 && !ready_o; i++) @(posedge clk);
    #1;
    chk("rst_end.ready_before", 64'(ready_o), 64'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("rst_end.ready", 64'(ready_o), 64'd0);
    chk("rst_end.result", result_o, 64'd0);
    $display("reset: outputs ready=%0d result=%h", ready_o, result_o);
    start_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    run_div("u_max_1", 32'hFFFFFFFF, 32'd1, 1'b0, {32'd0, 32'hFFFFFFFF});

    // Randomized divisions against the reference model
    for (int i = 0; i < 16; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0: rb = $urandom;
        1: rb = $urandom_range(1, 255);
        2: rb = $urandom >> $urandom_range(0, 31);
        default: rb = (i % 4 == 0) ? 32'd0 : 32'($urandom_range(1, 15));
      endcase
      rs = 1'($urandom_range(0, 1));
`ifdef DIV_SIGNED_EN
      ms = rs;
`else
      ms = 1'b0;
`endif
      run_div("rand", ra, rb, rs, model(ra, rb, ms));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
